// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
// Holds the default bubble word, the default reset PC and the fetch FSM encoding.
package fetch_stage_pkg;

  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HELD = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer parking a fetched word and its PC+4 while decode stalls.
// Clear takes priority over load.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  logic        valid_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc4_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      instr_reg <= 32'h0;
      pc4_reg   <= 32'h0;
    end else if (clear) begin
      valid_reg <= 1'b0;
      instr_reg <= 32'h0;
      pc4_reg   <= 32'h0;
    end else if (load) begin
      valid_reg <= 1'b1;
      instr_reg <= load_instr;
      pc4_reg   <= load_pc4;
    end
  end

  assign valid = valid_reg;
  assign instr = instr_reg;
  assign pc4   = pc4_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction memory handshake and IF/ID register.
// "repeat" is a reserved word, so that stall input is named repeat_stall.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        repeat_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  fetch_state_t state_reg, state_next;

  logic [31:0] pc_reg;
  logic        drop_reg;
  logic [31:0] drop_addr_reg;
  logic [31:0] ifid_instr_reg;
  logic [31:0] ifid_pc4_reg;
  logic        ifid_valid_reg;

  logic        stall;
  logic        in_held;
  logic        acked;
  logic        fetch_word;
  logic        skid_load;
  logic        skid_clear;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;

  assign stall = hold | repeat_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ:  if (fetch_word && stall) state_next = ST_HELD;
      ST_HELD: if (branch_taken || !stall) state_next = ST_REQ;
      default: state_next = ST_IDLE;
    endcase
  end

  // A word only counts as fetched when it was not requested before a redirect.
  always_comb begin
    imem_req   = (state_reg == ST_REQ);
    in_held    = (state_reg == ST_HELD);
    acked      = imem_req & imem_ack;
    fetch_word = acked & ~drop_reg & ~branch_taken;
    skid_load  = fetch_word & stall;
    skid_clear = branch_taken | (in_held & ~stall);
    imem_addr  = drop_reg ? drop_addr_reg : pc_reg;
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc4   (pc_reg + 32'd4),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc4        (skid_pc4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= word_align(RESET_PC);
      drop_reg       <= 1'b0;
      drop_addr_reg  <= 32'h0;
      ifid_instr_reg <= NOP_INSTR;
      ifid_pc4_reg   <= 32'h0;
      ifid_valid_reg <= 1'b0;
    end else if (branch_taken) begin
      pc_reg         <= word_align(branch_target);
      ifid_instr_reg <= NOP_INSTR;
      ifid_pc4_reg   <= 32'h0;
      ifid_valid_reg <= 1'b0;
      // Keep presenting the original address until the in-flight request is acked.
      if (imem_req && !imem_ack) begin
        drop_reg <= 1'b1;
        if (!drop_reg) drop_addr_reg <= pc_reg;
      end else begin
        drop_reg <= 1'b0;
      end
    end else if (acked && drop_reg) begin
      drop_reg <= 1'b0;
    end else if (fetch_word) begin
      pc_reg <= pc_reg + 32'd4;
      if (!stall) begin
        ifid_instr_reg <= imem_rdata;
        ifid_pc4_reg   <= pc_reg + 32'd4;
        ifid_valid_reg <= 1'b1;
      end
    end else if (in_held && !stall && skid_valid) begin
      ifid_instr_reg <= skid_instr;
      ifid_pc4_reg   <= skid_pc4;
      ifid_valid_reg <= 1'b1;
    end
  end

  assign ifid_instr = ifid_instr_reg;
  assign ifid_pc4   = ifid_pc4_reg;
  assign ifid_valid = ifid_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stall/ack/branch
// traffic compared against a queue-based reference model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        repeat_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  logic        ack_en = 1'b0;
  logic [31:0] mem_key = 32'h0;

  int checks = 0;
  int errors = 0;

  // Reference model: program-order view of the fetch stage.
  logic        m_started;
  logic [31:0] m_pc;
  word_t       m_park[$];
  logic [31:0] m_drop[$];
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;

  always #5 clk = ~clk;

  // Memory: answers only while a request is up; data is the address scrambled by mem_key.
  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = imem_addr ^ mem_key;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (TB_NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold          (hold),
    .repeat_stall  (repeat_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_pc      = 32'h0;
    m_park.delete();
    m_drop.delete();
    m_instr   = TB_NOP;
    m_pc4     = 32'h0;
    m_valid   = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic b, input logic [31:0] bt, input logic a);
    logic  req;
    logic  arrive;
    word_t w;
    req    = m_started && (m_park.size() == 0);
    arrive = req && a;
    if (b) begin
      m_instr = TB_NOP;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
      m_park.delete();
      if (arrive) m_drop.delete();
      else if (req && m_drop.size() == 0) m_drop.push_back(m_pc);
      m_pc = bt & 32'hFFFF_FFFC;
    end else if (arrive && m_drop.size() != 0) begin
      m_drop.delete();
    end else if (arrive) begin
      w.instr = m_pc ^ mem_key;
      w.pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      if (st) m_park.push_back(w);
      else begin
        m_instr = w.instr;
        m_pc4   = w.pc4;
        m_valid = 1'b1;
      end
    end else if (m_park.size() != 0 && !st) begin
      w       = m_park.pop_front();
      m_instr = w.instr;
      m_pc4   = w.pc4;
      m_valid = 1'b1;
    end
    m_started = 1'b1;
  endtask

  task automatic compare_all(input string tag);
    logic        exp_req;
    logic [31:0] exp_addr;
    exp_req  = m_started && (m_park.size() == 0);
    exp_addr = (m_drop.size() != 0) ? m_drop[0] : m_pc;
    chk({tag, " imem_req"},   {31'b0, imem_req},   {31'b0, exp_req});
    chk({tag, " imem_addr"},  imem_addr,           exp_addr);
    chk({tag, " ifid_instr"}, ifid_instr,          m_instr);
    chk({tag, " ifid_pc4"},   ifid_pc4,            m_pc4);
    chk({tag, " ifid_valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
    $display("t=%0t %s req=%0b addr=%h ifid=%h/%h/%0b", $time, tag, imem_req, imem_addr,
             ifid_instr, ifid_pc4, ifid_valid);
  endtask

  // One clock: drive at the negedge, advance the model, check at the next negedge.
  task automatic cyc(input string tag, input logic h, input logic r, input logic b,
                     input logic [31:0] bt, input logic a);
    hold          = h;
    repeat_stall  = r;
    branch_taken  = b;
    branch_target = bt;
    ack_en        = a;
    model_step(h | r, b, bt, a);
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    chk("reset addr", imem_addr, 32'h0);
    chk("reset instr", ifid_instr, TB_NOP);

    // Zero-wait memory returning the address as data.
    rst_n = 1'b1;
    #1;
    chk("idle req", {31'b0, imem_req}, 32'h0);
    cyc("zw1", 0, 0, 0, 0, 1);
    chk("zw1 addr", imem_addr, 32'h0);
    cyc("zw2", 0, 0, 0, 0, 1);
    chk("zw2 addr", imem_addr, 32'h4);
    chk("zw2 pc4", ifid_pc4, 32'h4);
    chk("zw2 valid", {31'b0, ifid_valid}, 32'h1);
    cyc("zw3", 0, 0, 0, 0, 1);
    chk("zw3 addr", imem_addr, 32'h8);
    chk("zw3 pc4", ifid_pc4, 32'h8);
    cyc("zw4", 0, 0, 0, 0, 1);
    chk("zw4 pc4", ifid_pc4, 32'hC);
    chk("zw4 instr", ifid_instr, 32'h8);

    // Double stall with 0x8C41_0004 in IF/ID.
    mem_key = 32'h8C41_0000;
    cyc("st_br", 0, 0, 1, 32'h0, 1);
    cyc("st_a", 0, 0, 0, 0, 1);
    cyc("st_b", 0, 0, 0, 0, 1);
    chk("st_b instr", ifid_instr, 32'h8C41_0004);
    cyc("stall1", 1, 1, 0, 0, 1);
    chk("stall1 instr", ifid_instr, 32'h8C41_0004);
    chk("stall1 pc", imem_addr, 32'hC);
    cyc("stall2", 1, 1, 0, 0, 1);
    chk("stall2 instr", ifid_instr, 32'h8C41_0004);
    chk("stall2 pc", imem_addr, 32'hC);
    cyc("unstall", 0, 0, 0, 0, 1);
    chk("unstall pc4", ifid_pc4, 32'hC);
    cyc("after", 0, 0, 0, 0, 1);
    chk("after pc4", ifid_pc4, 32'h10);

    // Slow ack at 0x10 with a stall on the ack cycle.
    for (int i = 0; i < 3; i++) begin
      cyc("wait", 0, 0, 0, 0, 0);
      chk("wait addr", imem_addr, 32'h10);
    end
    cyc("late_ack", 1, 0, 0, 0, 1);
    chk("late_ack req", {31'b0, imem_req}, 32'h0);
    chk("late_ack pc4", ifid_pc4, 32'h10);
    cyc("late_rel", 0, 0, 0, 0, 1);
    chk("late_rel pc4", ifid_pc4, 32'h14);

    // Branch while a request at 0x20 is outstanding.
    cyc("to20", 0, 0, 1, 32'h20, 1);
    cyc("br_out", 0, 0, 1, 32'h103, 0);
    chk("br_out addr", imem_addr, 32'h20);
    chk("br_out valid", {31'b0, ifid_valid}, 32'h0);
    cyc("drop", 0, 0, 0, 0, 1);
    chk("drop valid", {31'b0, ifid_valid}, 32'h0);
    chk("drop addr", imem_addr, 32'h100);
    cyc("tgt", 0, 0, 0, 0, 1);
    chk("tgt pc4", ifid_pc4, 32'h104);

    // Branch and stall together.
    cyc("br_st", 1, 0, 1, 32'h40, 1);
    chk("br_st instr", ifid_instr, TB_NOP);
    chk("br_st addr", imem_addr, 32'h40);
    cyc("br_st2", 0, 0, 0, 0, 1);
    chk("br_st2 pc4", ifid_pc4, 32'h44);

    // PC wrap.
    cyc("wrap_br", 0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
    cyc("wrap1", 0, 0, 0, 0, 1);
    chk("wrap1 pc4", ifid_pc4, 32'h0);
    cyc("wrap2", 0, 0, 0, 0, 1);
    chk("wrap2 pc4", ifid_pc4, 32'h4);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic        rh, rr, rb, ra;
      logic [31:0] rt;
      mem_key = $urandom;
      rh = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 3) == 0);
      rb = ($urandom_range(0, 11) == 0);
      ra = ($urandom_range(0, 9) < 6);
      rt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                       : ($urandom & 32'h0000_0FFF);
      cyc("rand", rh, rr, rb, rt, ra);
    end

    // Asynchronous reset mid-run, with an ack arriving while idle.
    cyc("pre_rst", 0, 0, 0, 0, 0);
    rst_n  = 1'b0;
    ack_en = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    compare_all("in_rst");
    rst_n = 1'b1;
    #1;
    chk("rel idle req", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 5; i++) cyc("post_rst", 0, 0, 0, 0, 1);
    chk("post_rst pc4", ifid_pc4, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
